// File: rtl/cla_nibble_sequencer_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The source/consumer drives through master; the adder sits on slave.
interface cla_nibble_sequencer_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             co;
   logic             ovf;

   modport master (
      output in_valid, a, b, ci, out_ready,
      input  in_ready, out_valid, sum, co, ovf
   );

   modport slave (
      input  in_valid, a, b, ci, out_ready,
      output in_ready, out_valid, sum, co, ovf
   );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit carry-lookahead slice,
// LSB nibble first, with the carry registered between nibbles.
module cla_nibble_sequencer #(
   parameter int unsigned WIDTH = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   cla_nibble_sequencer_if.slave bus
);
   localparam int unsigned NIBBLES = WIDTH / 4;
   localparam int unsigned IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int unsigned SHW     = IDXW + 2;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDXW-1:0]  r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_co;
   logic             r_ovf;

   logic             w_accept;
   logic             w_step;
   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_last;
   logic [SHW-1:0]   w_sh;
   logic [WIDTH-1:0] w_a_sh;
   logic [WIDTH-1:0] w_b_sh;
   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_s_pos;
   logic [3:0]       w_s;
   logic             w_co;

   assign w_last  = (r_idx == IDXW'(NIBBLES - 1));
   assign w_sh    = {r_idx, 2'b00};
   assign w_a_sh  = r_a >> w_sh;
   assign w_b_sh  = r_b >> w_sh;
   assign w_mask  = WIDTH'(4'hF) << w_sh;
   assign w_s_pos = WIDTH'(w_s) << w_sh;

   cla_4b u_cla (
      .CI (r_carry),
      .A  (w_a_sh[3:0]),
      .B  (w_b_sh[3:0]),
      .CO (w_co),
      .S  (w_s)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.in_valid)  w_state_nxt = S_RUN;
         S_RUN:   if (w_last)        w_state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
         default:                    w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = rst_n;
            w_accept   = bus.in_valid & rst_n;
         end
         S_RUN:   w_step      = 1'b1;
         S_DONE:  w_out_valid = 1'b1;
         default: ;
      endcase
   end

   // Operands are only consumed while RUN, so they need no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a <= bus.a;
         r_b <= bus.b;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_co    <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_carry <= bus.ci;
         r_idx   <= '0;
      end else if (w_step) begin
         r_sum   <= (r_sum & ~w_mask) | w_s_pos;
         r_carry <= w_co;
         if (w_last) begin
            r_co  <= w_co;
            r_ovf <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s[3] ^ w_co;
            r_idx <= '0;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.sum       = r_sum;
   assign bus.co        = r_co;
   assign bus.ovf       = r_ovf;
endmodule

// 4-bit carry-lookahead adder slice.
module cla_4b (
   input  logic       CI,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic       CO,
   output logic [3:0] S
);
   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [3:1] w_c;

   assign w_g = A & B;
   assign w_p = A ^ B;

   assign w_c[1] = w_g[0] | (w_p[0] & CI);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & CI);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & CI);
   assign CO     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & CI);

   assign S = w_p ^ {w_c, CI};
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for the nibble-serial adder: transaction-level model plus directed ops.
module tb_cla_nibble_sequencer;
   localparam int unsigned W   = 16;
   localparam int unsigned NIB = W / 4;

   logic clk;
   logic rst_n;

   cla_nibble_sequencer_if #(.WIDTH(W)) bus ();
   cla_nibble_sequencer_if #(.WIDTH(4)) bus4 ();

   cla_nibble_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   cla_nibble_sequencer #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: one op in flight, result visible NIB edges after accept.
   int          cyc = 0;
   int          due = 0;
   bit          have = 1'b0;
   bit          zero_flag = 1'b0;
   bit          started = 1'b0;
   logic [15:0] m_sum;
   bit          m_co;
   bit          m_ovf;

   initial begin
      logic [16:0] full;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            have      = 1'b0;
            zero_flag = 1'b1;
            started   = 1'b1;
         end else if (have && cyc >= due + 1 && bus.out_ready) begin
            have = 1'b0;
         end else if (!have && bus.in_valid) begin
            full      = {1'b0, bus.a} + {1'b0, bus.b} + {16'd0, bus.ci};
            m_sum     = full[15:0];
            m_co      = full[16];
            m_ovf     = (bus.a[15] == bus.b[15]) && (m_sum[15] != bus.a[15]);
            have      = 1'b1;
            due       = cyc + NIB;
            zero_flag = 1'b0;
         end
         cyc++;
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   initial begin
      bit exp_v;
      forever begin
         @(negedge clk);
         if (started) begin
            exp_v = have && (cyc >= due + 1);
            check("m_in_ready", 32'(bus.in_ready), 32'(rst_n && !have));
            check("m_out_valid", 32'(bus.out_valid), 32'(exp_v));
            if (exp_v) begin
               check("m_sum", 32'(bus.sum), 32'(m_sum));
               check("m_co", 32'(bus.co), 32'(m_co));
               check("m_ovf", 32'(bus.ovf), 32'(m_ovf));
            end
            if (zero_flag) begin
               check("m_zero_sum", 32'(bus.sum), 32'd0);
               check("m_zero_flags", {30'd0, bus.co, bus.ovf}, 32'd0);
            end
         end
      end
   end

   // Present operands for one cycle; caller is just after a rising edge with the DUT idle.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci);
      bus.a        = a;
      bus.b        = b;
      bus.ci       = ci;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      @(negedge clk);
      check("rdy_drop", 32'(bus.in_ready), 32'd0);
      while (!bus.out_valid && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      if (!bus.out_valid) check("out_timeout", 32'd0, 32'd1);
   endtask

   task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic ci, input logic [15:0] es, input logic eco, input logic eovf);
      int n;
      issue(a, b, ci);
      wait_out(n);
      check({tag, "_lat"}, 32'(n), 32'(NIB));
      check({tag, "_sum"}, 32'(bus.sum), 32'(es));
      check({tag, "_co"}, 32'(bus.co), 32'(eco));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(eovf));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.ci        = 1'b0;
      bus.out_ready = 1'b1;
      bus4.in_valid = 1'b0;
      bus4.a        = '0;
      bus4.b        = '0;
      bus4.ci       = 1'b0;
      bus4.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_sum", 32'(bus.sum), 32'd0);
      rst_n = 1'b1;

      op("zero",  16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
      op("xnib",  16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
      op("wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      op("sovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      op("cin",   16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

      // Backpressure: result held while inputs wiggle.
      bus.out_ready = 1'b0;
      op("bp", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = ~bus.in_valid;
         bus.a        = 16'($urandom);
         bus.b        = 16'($urandom);
         @(negedge clk);
         check("bp_hold_sum", 32'(bus.sum), 32'h0000);
         check("bp_hold_flags", {30'd0, bus.co, bus.ovf}, 32'd3);
         check("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
         check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a         = 16'h0001;
      bus.b         = 16'h0002;
      bus.ci        = 1'b0;
      @(posedge clk);
      #1;
      check("bp_idle_rdy", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wait_out(n);
      check("bp_next_lat", 32'(n), 32'(NIB));
      check("bp_next_sum", 32'(bus.sum), 32'h0003);
      @(posedge clk);
      #1;

      // Reset after two nibble edges.
      issue(16'hFFFF, 16'hFFFF, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mrst_sum", 32'(bus.sum), 32'd0);
      check("mrst_flags", {30'd0, bus.co, bus.ovf}, 32'd0);
      check("mrst_valid", 32'(bus.out_valid), 32'd0);
      check("mrst_rdy_low", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("mrst_rdy_high", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("mrst_no_valid", 32'(bus.out_valid), 32'd0);
      end
      @(posedge clk);
      #1;

      // Single-nibble instance.
      bus4.a        = 4'd15;
      bus4.b        = 4'd15;
      bus4.ci       = 1'b0;
      bus4.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bus4.out_valid && n < 10) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check("w4_lat", 32'(n), 32'd1);
      check("w4_sum", 32'(bus4.sum), 32'd14);
      check("w4_co", 32'(bus4.co), 32'd1);
      check("w4_ovf", 32'(bus4.ovf), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("w4_idle_rdy", 32'(bus4.in_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cla_nibble_sequencer.md
Name: cla_nibble_sequencer

Overview:
Multi-cycle wide adder that reuses one cla_4b slice, adding WIDTH-bit operands one nibble per cycle, LSB nibble first.
- Carry is registered between nibbles.
- Valid/ready handshakes on input and output.
- Sits between an operand source (bus/ALU front end) and a result consumer where area matters more than latency.
- Instantiates cla_4b unchanged: ports CI, A, B, CO, S.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of 4 and ≥ 4.
- NIBBLES, WIDTH/4, derived local parameter, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in for nibble 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  result, a+b+ci mod 2^WIDTH
- co  output  1  carry out of MSB nibble
- ovf  output  1  two's-complement signed overflow

Behaviour:
- One clock; reset is synchronous and active-low.
  - Sampled only on the rising edge of clk while rst_n=0.
  - Forces: state=IDLE, idx=0, carry=0, sum=0, co=0, ovf=0, out_valid=0.
  - in_ready=0 while rst_n=0.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE) & rst_n.
  - out_valid = (state==DONE).
- IDLE:
  - On edge with in_valid & in_ready: latch a, b into a_q, b_q; carry<=ci; idx<=0; go RUN.
  - in_valid without in_ready is ignored.
- RUN, one nibble per edge:
  - cla_4b inputs: A=a_q[4*idx+:4], B=b_q[4*idx+:4], CI=carry.
  - Each edge: sum[4*idx+:4]<=S; carry<=CO; idx<=idx+1.
  - When idx==NIBBLES-1: co<=CO; ovf<=a_q[WIDTH-1]^b_q[WIDTH-1]^S[3]^CO; idx<=0; go DONE.
  - The input handshake is ignored in RUN, and input ports are not sampled.
- DONE:
  - sum, co and ovf are held stable and do not change while out_valid=1 & out_ready=0.
  - On edge with out_ready=1: go IDLE. sum/co/ovf keep their last values in IDLE.
- Latency:
  - Accept edge E0; nibble k is written at edge E(k+1).
  - out_valid=1 from edge E(NIBBLES) onward.
  - Earliest next accept is edge E(NIBBLES+2), with out_ready held 1.
  - Minimum period: NIBBLES+2 cycles per operation.
- Partial results: sum bits of unprocessed nibbles keep their previous values during RUN. Only values seen with out_valid=1 are defined.
- Reset mid-RUN or mid-DONE:
  - Operation is aborted; no out_valid pulse.
  - in_ready=1 in the first cycle after rst_n returns high.
- Carry chain:
  - Carry propagates across nibble boundaries only through the carry register.
  - Never combinationally from the previous nibble's inputs.
- WIDTH=4 (NIBBLES=1): RUN lasts exactly one edge.
- idx width: max(1, clog2(NIBBLES)).

Test Plan:
All scenarios use WIDTH=16 unless noted.
- Reset then a=0x0000, b=0x0000, ci=0.
  - in_ready drops the cycle after accept; out_valid rises exactly 4 edges after the accept edge.
  - sum=0x0000, co=0, ovf=0.
- Cross-nibble carry: a=0x00FF, b=0x0001, ci=0 → sum=0x0100, co=0, ovf=0.
- Wrap-around: a=0xFFFF, b=0x0001, ci=0 → sum=0x0000, co=1, ovf=0.
- Signed overflow and carry-in:
  - a=0x7FFF, b=0x0001, ci=0 → sum=0x8000, co=0, ovf=1.
  - a=0x1234, b=0x4321, ci=1 → sum=0x5556, co=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid while toggling in_valid/a/b.
  - sum, co, ovf stay fixed; in_ready=0; no second accept.
  - Release out_ready: IDLE next cycle; a new op accepted one cycle later.
- Reset mid-RUN: assert rst_n=0 after 2 nibble edges.
  - out_valid never pulses; all outputs go to 0 at the reset edge.
  - in_ready=1 the first cycle after release.
  - WIDTH=4 instance: a=15, b=15, ci=0 → sum=14, co=1, out_valid 1 edge after accept.
